// File: rtl/seq_alu_core.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arithmetic ops plus a shift-add multiplier FSM.
// Optional build macro AUTO_SWEEP_EN replaces the op port with an internal opcode counter.
module seq_alu_core #(
  parameter int WIDTH    = 8,
  parameter bit MUL_FULL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic [3:0]       op_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam int         MSB    = WIDTH - 1;
  localparam int         CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  L_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  L_STEP1 = CW'(1);
  localparam logic [WIDTH:0] L_ONE   = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [CW-1:0]        r_step;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     w_mul_hi;
  logic [3:0]           w_op;
  logic                 w_accept;
  logic [WIDTH+1:0]     w_alu;

  // Returns {carry, overflow, result} for every single-cycle opcode.
  function automatic logic [WIDTH+1:0] f_alu(input logic [3:0] f_op,
                                             input logic [WIDTH-1:0] f_a,
                                             input logic [WIDTH-1:0] f_b);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    s = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (f_op)
      4'h0: begin
        s = {1'b0, f_a} + L_ONE;
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = ~f_a[MSB] & r[MSB];
      end
      4'h1: begin
        s = {1'b0, f_a} + {1'b0, f_b};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (f_a[MSB] == f_b[MSB]) & (r[MSB] != f_a[MSB]);
      end
      4'h2: begin
        s = {1'b0, f_a} - L_ONE;
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = f_a[MSB] & ~r[MSB];
      end
      4'h3: begin
        // Bit WIDTH of the extended difference is the borrow (a < b).
        s = {1'b0, f_a} - {1'b0, f_b};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (f_a[MSB] != f_b[MSB]) & (r[MSB] != f_a[MSB]);
      end
      4'h5: r[0] = (f_a == f_b);
      4'h6: r[0] = (f_a > f_b);
      4'h7: r[0] = (f_a < f_b);
      4'h8: r = ~f_a;
      4'h9: r = f_a & f_b;
      4'hA: r = f_a | f_b;
      4'hB: r = ~(f_a & f_b);
      4'hC: r = ~(f_a | f_b);
      4'hD: r = f_a ^ f_b;
      4'hE: begin
        r = f_a >> 1;
        c = f_a[0];
      end
      4'hF: begin
        r = f_a << 1;
        c = f_a[MSB];
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_alu     = f_alu(w_op, a, b);
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_hi  = MUL_FULL ? w_acc_nxt[2*WIDTH-1:WIDTH] : '0;

`ifdef AUTO_SWEEP_EN
  logic [3:0] r_sweep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sweep <= 4'h0;
    end else if (w_accept) begin
      r_sweep <= r_sweep + 4'h1;
    end
  end

  assign w_op = r_sweep;
`else
  assign w_op = op;
`endif

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      res     <= '0;
      res_hi  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_v  <= 1'b0;
      op_out  <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state <= S_MUL;
              r_step  <= '0;
            end else begin
              r_state <= S_DONE;
              res     <= w_alu[WIDTH-1:0];
              res_hi  <= '0;
              flag_c  <= w_alu[WIDTH+1];
              flag_v  <= w_alu[WIDTH];
              flag_z  <= (w_alu[WIDTH-1:0] == '0);
              op_out  <= w_op;
            end
          end
        end
        S_MUL: begin
          // The last partial product is folded in on the same edge that enters DONE.
          if (r_step == L_LAST) begin
            r_state <= S_DONE;
            res     <= w_acc_nxt[WIDTH-1:0];
            res_hi  <= w_mul_hi;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_z  <= ({w_mul_hi, w_acc_nxt[WIDTH-1:0]} == '0);
            op_out  <= OP_MUL;
          end else begin
            r_step <= r_step + L_STEP1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Multiplier datapath
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core: arithmetic reference model with per-cycle compare plus directed cases.
module tb_seq_alu_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [W-1:0] res_hi;
  logic         flag_c;
  logic         flag_z;
  logic         flag_v;
  logic [3:0]   op_out;

  int n_chk  = 0;
  int n_fail = 0;
  longint cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         v;
    logic [3:0]   op;
    longint       due;
  } exp_t;

  exp_t       q[$];
  logic [3:0] sweep_cnt;

  seq_alu_core #(.WIDTH(W), .MUL_FULL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .flag_c(flag_c), .flag_z(flag_z),
    .flag_v(flag_v), .op_out(op_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input int o, input longint x, input longint y);
    exp_t   e;
    longint m  = (longint'(1) << W) - 1;
    longint hm = longint'(1) << (W - 1);
    longint sx = (x >= hm) ? x - (m + 1) : x;
    longint sy = (y >= hm) ? y - (m + 1) : y;
    longint r  = 0;
    longint h  = 0;
    longint t;
    bit     c  = 0;
    bit     v  = 0;
    case (o)
      0: begin t = x + 1; r = t & m; c = (t > m); v = (sx + 1 > hm - 1); end
      1: begin t = x + y; r = t & m; c = (t > m); v = (sx + sy > hm - 1) || (sx + sy < -hm); end
      2: begin r = (x - 1) & m; c = (x == 0); v = (sx - 1 < -hm); end
      3: begin r = (x - y) & m; c = (x < y); v = (sx - sy > hm - 1) || (sx - sy < -hm); end
      4: begin t = x * y; r = t & m; h = t >> W; end
      5: r = (x == y) ? 1 : 0;
      6: r = (x > y) ? 1 : 0;
      7: r = (x < y) ? 1 : 0;
      8: r = ~x & m;
      9: r = x & y;
      10: r = x | y;
      11: r = ~(x & y) & m;
      12: r = ~(x | y) & m;
      13: r = x ^ y;
      14: begin r = x >> 1; c = x[0]; end
      default: begin r = (x << 1) & m; c = x[W-1]; end
    endcase
    e.res = W'(r);
    e.hi  = W'(h);
    e.c   = c;
    e.v   = v;
    e.z   = (r == 0) && (h == 0);
    e.op  = 4'(o);
    e.due = 0;
    return e;
  endfunction

  // Cycle-by-cycle comparison against the reference queue
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      sweep_cnt = 4'h0;
    end else begin
      logic exp_ready;
      logic exp_valid;
      exp_t e;
      int   eop;
      exp_ready = (q.size() == 0);
      exp_valid = (q.size() > 0) && (cyc >= q[0].due);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("res", res, q[0].res);
        chk("res_hi", res_hi, q[0].hi);
        chk("flag_c", flag_c, q[0].c);
        chk("flag_z", flag_z, q[0].z);
        chk("flag_v", flag_v, q[0].v);
        chk("op_out", op_out, q[0].op);
        if (out_ready) void'(q.pop_front());
      end else if (in_valid && exp_ready) begin
`ifdef AUTO_SWEEP_EN
        eop = int'(sweep_cnt);
        sweep_cnt = sweep_cnt + 4'h1;
`else
        eop = int'(op);
`endif
        e = model(eop, longint'(a), longint'(b));
        e.due = cyc + 1 + ((eop == 4) ? W : 0);
        q.push_back(e);
      end
    end
  end

  task automatic do_txn(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, output logic [W-1:0] r, output logic [W-1:0] rh,
                        output logic c, output logic z, output logic v,
                        output logic [3:0] oo, output int lat);
    int n;
    a = x; b = y; op = o; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    lat = 1; n = 0;
    while (!out_valid && n < 50) begin
      chk("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      lat++; n++;
    end
    chk("result_timeout", out_valid, 1);
    r = res; rh = res_hi; c = flag_c; z = flag_z; v = flag_v; oo = op_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_res", {res_hi, res}, {rh, r});
      chk("hold_flags", {flag_c, flag_z, flag_v, op_out}, {c, z, v, oo});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_release", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r, rh;
    logic         c, z, v;
    logic [3:0]   oo;
    int           lat;
    exp_t         m;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {res_hi, res, flag_c, flag_z, flag_v, op_out}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    m = model(1, 'hFF, 'h01);
    chk("model_add_ff_01", {m.res, m.c, m.z, m.v}, {8'h00, 3'b110});
    m = model(3, 'h80, 'h01);
    chk("model_sub_80_01", {m.res, m.c, m.v}, {8'h7F, 2'b01});
    m = model(4, 'hFF, 'hFF);
    chk("model_mul_ff_ff", {m.hi, m.res}, 16'hFE01);

`ifdef AUTO_SWEEP_EN
    for (int i = 0; i < 17; i++) begin
      do_txn(4'h0, 8'h05, 8'h03, 0, r, rh, c, z, v, oo, lat);
      chk("sweep_op_out", oo, i % 16);
      if (i == 4) chk("sweep_mul", {rh, r}, 16'h000F);
      if (i == 15) chk("sweep_shl", r, 8'h0A);
    end
`else
    do_txn(4'h1, 8'hFF, 8'h01, 0, r, rh, c, z, v, oo, lat);
    chk("add_ff_01", {r, c, z, v}, {8'h00, 3'b110});
    chk("add_latency", lat, 1);
    do_txn(4'h3, 8'h80, 8'h01, 0, r, rh, c, z, v, oo, lat);
    chk("sub_80_01", {r, c, v}, {8'h7F, 2'b01});
    do_txn(4'h0, 8'hFF, 8'h00, 5, r, rh, c, z, v, oo, lat);
    chk("inc_ff_hold", {r, c, z, oo}, {8'h00, 2'b11, 4'h0});
    do_txn(4'h3, 8'h03, 8'h05, 0, r, rh, c, z, v, oo, lat);
    chk("sub_3_5", {r, c}, {8'hFE, 1'b1});
    do_txn(4'h4, 8'hFF, 8'hFF, 2, r, rh, c, z, v, oo, lat);
    chk("mul_ff_ff", {rh, r}, 16'hFE01);
    chk("mul_latency", lat, W + 1);
    chk("mul_flags", {c, z, v, oo}, {3'b000, 4'h4});

    a = 8'hFF; b = 8'hFF; op = 4'h4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midmul_rst_outputs", {res_hi, res, flag_c, flag_z, flag_v, op_out}, 0);
    chk("midmul_rst_valid", out_valid, 0);
    chk("midmul_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      a  = W'($urandom);
      b  = W'($urandom);
      op = 4'($urandom);
      if (i % 7 == 0) a = (i % 2 == 0) ? '1 : '0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("drain_idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
